// File: rtl/oled_spi_receiver.sv
// Purpose : receive end of a 4-wire SSD1306-style OLED SPI link, decoded into a 1 KiB frame buffer.
// Latency : rx_byte_valid SYNC_STAGES+1 clk after the 8th sclk rise; frame buffer write in that cycle; rd_data 1 clk.
// Backpr. : none -- the SPI master cannot be stalled; clk must run at >= 4x io_sclk so no edge is lost.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   io_sclk/io_sdin/io_cs/  raw SPI pins (async to clk, synchronized internally)
//   io_dc/io_reset
//   rd_addr -> rd_data      frame buffer read port, registered, read-before-write
//   rx_byte_valid/rx_byte/  one-cycle strobe per received byte with its dc flag
//   rx_is_data
//   frame_done              pulse when a data write wraps the page/column window
//   display_on              0xAF / 0xAE state
//   frame_count/abort_count statistics, only live when OLED_RX_STATS_EN is defined
module oled_spi_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 128,
    parameter int PAGES       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_sclk,
    input  logic        io_sdin,
    input  logic        io_cs,
    input  logic        io_dc,
    input  logic        io_reset,
    input  logic [9:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        rx_byte_valid,
    output logic [7:0]  rx_byte,
    output logic        rx_is_data,
    output logic        frame_done,
    output logic        display_on,
    output logic [15:0] frame_count,
    output logic [15:0] abort_count
);

    localparam int FB_DEPTH = COLS * PAGES;
    localparam int COL_W    = $clog2(COLS);
    localparam int PAGE_W   = $clog2(PAGES);
    localparam int ADDR_W   = $clog2(FB_DEPTH);

    localparam logic [COL_W-1:0]  COL_ONE  = 1;
    localparam logic [PAGE_W-1:0] PAGE_ONE = 1;

    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
    localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
    localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;

    // Synchronizer bit order {reset, dc, cs, sdin, sclk}; cs and reset come up inactive.
    localparam logic [4:0] SYNC_RST = 5'b10100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COL_START,
        ST_COL_END,
        ST_PAGE_START,
        ST_PAGE_END
    } state_t;

    // ---------------------------------------------------------------- input sync
    logic [4:0] sync_q [SYNC_STAGES];
    logic       s_sclk, s_sdin, s_cs, s_dc, disp_rst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {io_reset, io_dc, io_cs, io_sdin, io_sclk};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_sclk   = sync_q[SYNC_STAGES-1][0];
    assign s_sdin   = sync_q[SYNC_STAGES-1][1];
    assign s_cs     = sync_q[SYNC_STAGES-1][2];
    assign s_dc     = sync_q[SYNC_STAGES-1][3];
    assign disp_rst = ~sync_q[SYNC_STAGES-1][4];

    // ---------------------------------------------------------------- byte assembly
    logic       sclk_prev;
    logic       sclk_rise;
    logic [2:0] bit_cnt;
    logic [6:0] shift_q;

    assign sclk_rise = s_sclk & ~sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev     <= 1'b0;
            bit_cnt       <= 3'd0;
            shift_q       <= 7'd0;
            rx_byte       <= 8'd0;
            rx_byte_valid <= 1'b0;
            rx_is_data    <= 1'b0;
        end else begin
            sclk_prev     <= s_sclk;
            rx_byte_valid <= 1'b0;
            if (disp_rst) begin
                bit_cnt    <= 3'd0;
                shift_q    <= 7'd0;
                rx_byte    <= 8'd0;
                rx_is_data <= 1'b0;
            end else if (s_cs) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shift_q <= {shift_q[5:0], s_sdin};
                if (bit_cnt == 3'd7) begin
                    // dc travels through the same synchronizer depth as sdin, so it
                    // is aligned with the last bit here.
                    rx_byte       <= {shift_q, s_sdin};
                    rx_is_data    <= s_dc;
                    rx_byte_valid <= 1'b1;
                    bit_cnt       <= 3'd0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- command FSM
    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        state_q <= ST_IDLE;
        else if (disp_rst) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rx_byte_valid) begin
            if (rx_is_data) begin
                // A data byte cancels any pending addressing parameter.
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_byte == CMD_COL_ADDR)       state_d = ST_COL_START;
                        else if (rx_byte == CMD_PAGE_ADDR) state_d = ST_PAGE_START;
                    end
                    ST_COL_START:  state_d = ST_COL_END;
                    ST_COL_END:    state_d = ST_IDLE;
                    ST_PAGE_START: state_d = ST_PAGE_END;
                    ST_PAGE_END:   state_d = ST_IDLE;
                    default:       state_d = ST_IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- address window / pointer
    logic [COL_W-1:0]  col, col_start, col_end;
    logic [PAGE_W-1:0] page, page_start, page_end;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_waddr;

    assign fb_we    = rx_byte_valid & rx_is_data & ~disp_rst;
    assign fb_waddr = {page, col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            col_start  <= '0;
            col_end    <= '1;
            page       <= '0;
            page_start <= '0;
            page_end   <= '1;
            display_on <= 1'b0;
            frame_done <= 1'b0;
        end else if (disp_rst) begin
            col        <= '0;
            col_start  <= '0;
            col_end    <= '1;
            page       <= '0;
            page_start <= '0;
            page_end   <= '1;
            display_on <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (rx_byte_valid) begin
                if (rx_is_data) begin
                    // Pointers wrap naturally at the power-of-two limits, which gives
                    // the start>end window behaviour for free.
                    if (col != col_end) begin
                        col <= col + COL_ONE;
                    end else begin
                        col <= col_start;
                        if (page != page_end) begin
                            page <= page + PAGE_ONE;
                        end else begin
                            page       <= page_start;
                            frame_done <= 1'b1;
                        end
                    end
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (rx_byte == CMD_DISP_ON)       display_on <= 1'b1;
                            else if (rx_byte == CMD_DISP_OFF) display_on <= 1'b0;
                        end
                        ST_COL_START:  col_start <= rx_byte[COL_W-1:0];
                        ST_COL_END: begin
                            col_end <= rx_byte[COL_W-1:0];
                            col     <= col_start;
                        end
                        ST_PAGE_START: page_start <= rx_byte[PAGE_W-1:0];
                        ST_PAGE_END: begin
                            page_end <= rx_byte[PAGE_W-1:0];
                            page     <= page_start;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------------------------------------------------------- frame buffer
    // Contents survive both resets so a captured frame can still be read out.
    logic [7:0] fb [FB_DEPTH];

    always_ff @(posedge clk) begin
        if (fb_we) fb[fb_waddr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= 8'd0;
        else        rd_data <= fb[rd_addr];
    end

    // ---------------------------------------------------------------- statistics
`ifdef OLED_RX_STATS_EN
    logic        abort_pulse;
    logic [15:0] frame_cnt_q, abort_cnt_q;

    // cs is a level, but bit_cnt clears on the first cycle so this fires once.
    assign abort_pulse = s_cs & ~disp_rst & (bit_cnt != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
            abort_cnt_q <= 16'd0;
        end else begin
            if (frame_done)  frame_cnt_q <= frame_cnt_q + 16'd1;
            if (abort_pulse) abort_cnt_q <= abort_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign abort_count = abort_cnt_q;
`else
    assign frame_count = 16'd0;
    assign abort_count = 16'd0;
`endif

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: received bytes are scoreboarded, frame
// buffer contents are read back through rd_addr and compared against constants.
module tb_oled_spi_receiver;

`ifdef OLED_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_sclk, io_sdin, io_cs, io_dc, io_reset;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        rx_is_data;
    logic        frame_done;
    logic        display_on;
    logic [15:0] frame_count;
    logic [15:0] abort_count;

    int n_checks = 0;
    int n_pass   = 0;
    int frame_done_cnt = 0;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    oled_spi_receiver #(.SYNC_STAGES(2), .COLS(128), .PAGES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_sclk      (io_sclk),
        .io_sdin      (io_sdin),
        .io_cs        (io_cs),
        .io_dc        (io_dc),
        .io_reset     (io_reset),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rx_byte_valid(rx_byte_valid),
        .rx_byte      (rx_byte),
        .rx_is_data   (rx_is_data),
        .frame_done   (frame_done),
        .display_on   (display_on),
        .frame_count  (frame_count),
        .abort_count  (abort_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard monitor: every received byte must match the next queued one.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_done === 1'b1) frame_done_cnt++;
            if (rx_byte_valid === 1'b1) begin
                n_checks++;
                assert (exp_q.size() != 0) n_pass++;
                else $error("FAIL sb_extra observed=%0h expected=none", rx_byte);
                if (exp_q.size() != 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("sb_byte", {24'd0, rx_byte}, {24'd0, e[7:0]});
                    chk("sb_dc", {31'd0, rx_is_data}, {31'd0, e[8]});
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            io_sdin = b[7-i];
            io_sclk = 1'b0;
            repeat (2) @(negedge clk);
            io_sclk = 1'b1;
            repeat (2) @(negedge clk);
        end
        io_sclk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        exp_q.push_back({dc, b});
        io_dc = dc;
        send_bits(b, 8);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [9:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(posedge clk);
        #1 d = rd_data;
    endtask

    task automatic select_cs();
        @(negedge clk);
        io_cs = 1'b0;
        wait_clk(4);
    endtask

    initial begin
        logic [7:0] d;
        int         fb_before;

        rst_n = 1'b0; io_sclk = 1'b0; io_sdin = 1'b0; io_cs = 1'b1;
        io_dc = 1'b0; io_reset = 1'b1; rd_addr = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid",   {31'd0, rx_byte_valid}, 32'd0);
        chk("rst_byte",    {24'd0, rx_byte},       32'd0);
        chk("rst_is_data", {31'd0, rx_is_data},    32'd0);
        chk("rst_disp",    {31'd0, display_on},    32'd0);
        chk("rst_fdone",   {31'd0, frame_done},    32'd0);
        chk("rst_fcnt",    {16'd0, frame_count},   32'd0);
        chk("rst_acnt",    {16'd0, abort_count},   32'd0);
        chk("rst_rd",      {24'd0, rd_data},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        select_cs();

        // Display on command
        send_byte(8'hAF, 1'b0);
        wait_clk(6);
        chk("disp_on", {31'd0, display_on}, 32'd1);
        chk("af_byte", {24'd0, rx_byte}, 32'hAF);

        // Full frame of data 0..255 repeating
        for (int i = 0; i < 1023; i++) send_byte(8'(i), 1'b1);
        wait_clk(6);
        chk("frame_early", frame_done_cnt, 32'd0);
        send_byte(8'hFF, 1'b1);
        wait_clk(6);
        chk("frame_once", frame_done_cnt, 32'd1);
        for (int i = 0; i < 1024; i++) begin
            rd(10'(i), d);
            chk("fb_full", {24'd0, d}, {24'd0, 8'(i)});
        end
        send_byte(8'hEE, 1'b1);   // pointer must be back at col 0 page 0
        wait_clk(6);
        rd(10'd0, d);
        chk("wrap_ptr", {24'd0, d}, 32'hEE);

        // Addressing window col 0x10..0x11, page 2..3
        send_byte(8'h21, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'hA0, 1'b1); send_byte(8'hA1, 1'b1); send_byte(8'hA2, 1'b1);
        wait_clk(6);
        chk("win_no_frame", frame_done_cnt, 32'd1);
        send_byte(8'hA3, 1'b1);
        wait_clk(6);
        chk("win_frame", frame_done_cnt, 32'd2);
        rd(10'h110, d); chk("win_a0", {24'd0, d}, 32'hA0);
        rd(10'h111, d); chk("win_a1", {24'd0, d}, 32'hA1);
        rd(10'h190, d); chk("win_a2", {24'd0, d}, 32'hA2);
        rd(10'h191, d); chk("win_a3", {24'd0, d}, 32'hA3);

        // Partial byte aborted by cs release, then a full byte
        io_dc = 1'b0;
        send_bits(8'hFF, 5);
        io_cs = 1'b1;
        wait_clk(6);
        select_cs();
        send_byte(8'h3C, 1'b0);
        wait_clk(6);
        chk("abort_byte", {24'd0, rx_byte}, 32'h3C);
        chk("abort_cnt", {16'd0, abort_count}, STATS ? 32'd1 : 32'd0);

        // Data during parameter state: FSM back to IDLE, window unchanged
        send_byte(8'h21, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'hAE, 1'b0);   // only honoured if FSM is IDLE
        wait_clk(6);
        chk("param_idle", {31'd0, display_on}, 32'd0);
        send_byte(8'hAF, 1'b0);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        wait_clk(6);
        rd(10'h110, d); chk("param_55", {24'd0, d}, 32'h55);
        rd(10'h111, d); chk("param_66", {24'd0, d}, 32'h66);
        rd(10'h190, d); chk("param_77", {24'd0, d}, 32'h77);
        chk("fcnt", {16'd0, frame_count}, STATS ? 32'd2 : 32'd0);

        // Display reset mid-frame at col 40 page 3
        send_byte(8'h21, 1'b0); send_byte(8'h28, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h07, 1'b0);
        send_byte(8'h11, 1'b1);
        wait_clk(6);
        @(negedge clk);
        io_cs = 1'b1;
        io_reset = 1'b0;
        wait_clk(10);
        chk("dr_disp", {31'd0, display_on}, 32'd0);
        chk("dr_byte", {24'd0, rx_byte}, 32'd0);
        chk("dr_acnt", {16'd0, abort_count}, STATS ? 32'd1 : 32'd0);
        io_reset = 1'b1;
        wait_clk(6);
        select_cs();
        fb_before = frame_done_cnt;
        send_byte(8'h99, 1'b1);
        send_byte(8'h9A, 1'b1);
        wait_clk(6);
        rd(10'd0,   d); chk("dr_fb0",   {24'd0, d}, 32'h99);
        rd(10'd1,   d); chk("dr_fb1",   {24'd0, d}, 32'h9A);
        rd(10'd424, d); chk("dr_fb424", {24'd0, d}, 32'h11);
        chk("dr_no_frame", frame_done_cnt, fb_before);
        chk("dr_fcnt", {16'd0, frame_count}, STATS ? 32'd2 : 32'd0);

        wait_clk(10);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
